// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage between the PC register and the IF/ID boundary.
// Issues in-order requests to instruction memory (req/gnt/rvalid). Each request
// allocates a queue entry at issue. The response fills that entry, and the head
// entry is presented to decode with valid/ready. A flush drops the queue
// contents. It also arranges for responses already in flight to be discarded
// when they return.
//
// Optional feature macro: IFQ_ALIGN_CHECK_EN
//   When defined, a PC with pc_i[1:0] != 0 is not sent to memory. It is queued
//   as a pre-filled entry with inst = 0 and a misalign flag, and the flag is
//   reported on id_misalign_o.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_i, pc_ce_i   PC stream from the PC register; stall_req_o holds it
//   flush_i         drop queue contents and in-flight responses
//   imem_*          request/grant/response handshake to instruction memory
//   id_*            head entry to decode (valid/ready)
//   id_misalign_o   head misalign flag (IFQ_ALIGN_CHECK_EN only)
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          pc_ce_i,
  output logic          stall_req_o,
  input  logic          flush_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          id_valid_o,
  output logic [AW-1:0] id_pc_o,
  output logic [DW-1:0] id_inst_o,
`ifdef IFQ_ALIGN_CHECK_EN
  output logic          id_misalign_o,
`endif
  input  logic          id_ready_i
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  // Discard counter carries an extra bit: repeated flushes while earlier
  // discards are still pending can push the in-flight total past DEPTH.
  localparam int unsigned DCW = CW + 1;

  logic [AW-1:0]  r_pc     [DEPTH];
  logic [DW-1:0]  r_inst   [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_pend;      // requests in flight that own a queue entry
  logic [DCW-1:0] r_discard;   // responses in flight that must be dropped
`ifdef IFQ_ALIGN_CHECK_EN
  logic [DEPTH-1:0] r_mis;
`else
  logic [PW-1:0]  r_fill_ptr;
`endif

  logic           w_credit;
  logic           w_misaligned;
  logic           w_gate;
  logic           w_issue;
  logic           w_mis_alloc;
  logic           w_alloc;
  logic           w_head_live;
  logic           w_pop;
  logic           w_drop;
  logic           w_fill;
  logic [PW-1:0]  w_fill_idx;
  logic [DCW-1:0] w_inflight;
  logic [DCW-1:0] w_flush_discard;

`ifdef IFQ_ALIGN_CHECK_EN
  assign w_misaligned = (pc_i[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Request / stall: credit counts allocated-but-unfilled entries too.
  assign w_credit    = (r_count < CW'(DEPTH));
  assign w_gate      = pc_ce_i & w_credit & ~flush_i & ~rst;
  assign imem_req_o  = w_gate & ~w_misaligned;
  assign imem_addr_o = pc_i;
  assign w_issue     = imem_req_o & imem_gnt_i;
  assign w_mis_alloc = w_gate & w_misaligned;
  assign w_alloc     = w_issue | w_mis_alloc;
  assign stall_req_o = pc_ce_i & ~w_alloc & ~rst;

  // Decode side: head data shows as zero until the head entry is complete.
  assign w_head_live = (r_count != '0) & r_filled[r_head];
  assign id_valid_o  = w_head_live & ~flush_i & ~rst;
  assign id_pc_o     = w_head_live ? r_pc[r_head]   : '0;
  assign id_inst_o   = w_head_live ? r_inst[r_head] : '0;
  assign w_pop       = id_valid_o & id_ready_i;
`ifdef IFQ_ALIGN_CHECK_EN
  assign id_misalign_o = id_valid_o & r_mis[r_head];
`endif

  // Responses: stale ones are dropped first; a response with nothing
  // outstanding is ignored.
  assign w_drop = imem_rvalid_i & (r_discard != '0);
  assign w_fill = imem_rvalid_i & (r_discard == '0) & (r_pend != '0);

  // On flush, everything still in flight becomes a discard, less the response
  // returning in the flush cycle itself.
  assign w_inflight      = r_discard + DCW'(r_pend);
  assign w_flush_discard = w_inflight - DCW'(imem_rvalid_i && (w_inflight != '0));

`ifdef IFQ_ALIGN_CHECK_EN
  // Pre-filled misaligned entries sit between fetched ones, so the fill target
  // is the oldest unfilled live entry, found by scanning from the head.
  always_comb begin
    logic [PW-1:0] w_idx;
    logic          w_found;
    w_fill_idx = r_head;
    w_idx      = r_head;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (!w_found && (CW'(i) < r_count) && !r_filled[w_idx]) begin
        w_fill_idx = w_idx;
        w_found    = 1'b1;
      end
    end
  end
`else
  assign w_fill_idx = r_fill_ptr;
`endif

  // Queue state; flush outranks pop, issue and fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pend    <= '0;
      r_discard <= '0;
      r_filled  <= '0;
`ifdef IFQ_ALIGN_CHECK_EN
      r_mis     <= '0;
`else
      r_fill_ptr <= '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (flush_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pend    <= '0;
      r_discard <= w_flush_discard;
`ifndef IFQ_ALIGN_CHECK_EN
      r_fill_ptr <= '0;
`endif
    end else begin
      if (w_alloc) begin
        r_pc[r_tail]     <= pc_i;
        r_inst[r_tail]   <= '0;
        r_filled[r_tail] <= w_mis_alloc;
`ifdef IFQ_ALIGN_CHECK_EN
        r_mis[r_tail]    <= w_mis_alloc;
`endif
        r_tail <= r_tail + PW'(1);
      end
      if (w_fill) begin
        r_inst[w_fill_idx]   <= imem_rdata_i;
        r_filled[w_fill_idx] <= 1'b1;
`ifndef IFQ_ALIGN_CHECK_EN
        r_fill_ptr <= r_fill_ptr + PW'(1);
`endif
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_drop) begin
        r_discard <= r_discard - DCW'(1);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      r_pend  <= r_pend + CW'(w_issue) - CW'(w_fill);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: a combinational gating table plus scoreboarded
// fetch sequences against a behavioural in-order memory with configurable
// latency and a response hold.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] MASK  = 32'hFFFF0000;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        i_pc_ce;
  logic        o_stall;
  logic        i_flush;
  logic        o_req;
  logic [31:0] o_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        o_valid;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  logic        i_ready;
`ifdef IFQ_ALIGN_CHECK_EN
  logic        o_mis;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (i_rst),
    .pc_i         (i_pc),
    .pc_ce_i      (i_pc_ce),
    .stall_req_o  (o_stall),
    .flush_i      (i_flush),
    .imem_req_o   (o_req),
    .imem_addr_o  (o_addr),
    .imem_gnt_i   (i_gnt),
    .imem_rvalid_i(i_rvalid),
    .imem_rdata_i (i_rdata),
    .id_valid_o   (o_valid),
    .id_pc_o      (o_id_pc),
    .id_inst_o    (o_id_inst),
`ifdef IFQ_ALIGN_CHECK_EN
    .id_misalign_o(o_mis),
`endif
    .id_ready_i   (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    string name;
    logic  rst;
    logic  ce;
    logic  gnt;
    logic  flush;
    logic  exp_req;
    logic  exp_stall;
    logic  exp_valid;
  } vec_t;

  exp_t  sb[$];
  mreq_t mem_q[$];
  vec_t  vt[6];

  int errors, checks;
  int cyc, lat, left;
  logic hold;
  int grants, pops, first_grant, first_valid, first_pop, last_pop, resume, max_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory response, sample at negedge, update model.
  task automatic step();
    logic consumed;
    exp_t e;
    i_pc_ce = (left > 0);
    if (!hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      i_rvalid = 1'b1;
      i_rdata  = mem_q[0].addr ^ MASK;
    end else begin
      i_rvalid = 1'b0;
      i_rdata  = '0;
    end
    @(negedge clk);
    assert (!(i_rvalid && mem_q.size() == 0));
    if (i_rvalid) void'(mem_q.pop_front());
    if (o_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h, nothing expected (cycle %0d)", o_id_pc, cyc);
        end else begin
          e = sb.pop_front();
          chk("id_pc", o_id_pc, e.pc);
          chk("id_inst", o_id_inst, e.inst);
`ifdef IFQ_ALIGN_CHECK_EN
          chk("id_misalign", 32'(o_mis), 32'(e.mis));
`endif
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (o_req && i_gnt) begin
      chk("imem_addr", o_addr, i_pc);
      mem_q.push_back('{addr: i_pc, due: cyc + lat});
      grants++;
      if (first_grant < 0) first_grant = cyc;
      if (first_pop >= 0 && resume < 0) resume = cyc;
      if (mem_q.size() > max_out) max_out = mem_q.size();
    end
    consumed = i_pc_ce && !o_stall;
    if (consumed) begin
      e.pc = i_pc;
`ifdef IFQ_ALIGN_CHECK_EN
      e.mis  = (i_pc[1:0] != 2'b00);
      e.inst = e.mis ? 32'h0 : (i_pc ^ MASK);
`else
      e.mis  = 1'b0;
      e.inst = i_pc ^ MASK;
`endif
      sb.push_back(e);
    end
    if (i_flush) sb.delete();
    chk("occupancy_le_depth", 32'(sb.size() <= DEPTH), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    if (consumed) begin
      i_pc = i_pc + 32'd4;
      left--;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_pc_ce = 1'b0; i_flush = 1'b0; i_gnt = 1'b0;
    i_ready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_pc = '0;
    left = 0; hold = 1'b0; lat = 1;
    mem_q.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    cyc = 0; grants = 0; pops = 0; first_grant = -1; first_valid = -1;
    first_pop = -1; last_pop = -1; resume = -1; max_out = 0;
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    for (int k = 0; k < budget && pops < n; k++) step();
    chk(name, 32'(pops), 32'(n));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vt[0] = '{"in_reset",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"idle",         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{"req_no_gnt",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{"req_gnt",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{"flush_ce",     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{"flush_idle",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state and combinational request/stall gating on an empty queue.
    do_reset();
    chk("reset_id_pc", o_id_pc, 32'h0);
    chk("reset_id_inst", o_id_inst, 32'h0);
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      i_rst = vt[v].rst; i_pc_ce = vt[v].ce; i_gnt = vt[v].gnt; i_flush = vt[v].flush;
      i_pc = 32'h40;
      #1;
      chk({vt[v].name, "_req"},   32'(o_req),   32'(vt[v].exp_req));
      chk({vt[v].name, "_stall"}, 32'(o_stall), 32'(vt[v].exp_stall));
      chk({vt[v].name, "_valid"}, 32'(o_valid), 32'(vt[v].exp_valid));
      #1;
      i_rst = 1'b0; i_pc_ce = 1'b0; i_gnt = 1'b0; i_flush = 1'b0;
    end

    // Sequential stream, 1-cycle memory.
    do_reset();
    lat = 1; i_gnt = 1'b1; i_ready = 1'b1; i_pc = 32'h0; left = 3;
    wait_pops("t1_pops", 3, 50);
    chk("t1_grants", 32'(grants), 32'd3);
    chk("t1_latency", 32'(first_valid - first_grant), 32'd2);

    // Fill to DEPTH with decode stalled, then drain.
    do_reset();
    lat = 1; i_gnt = 1'b1; i_ready = 1'b0; i_pc = 32'h40; left = 8;
    repeat (8) step();
    chk("t2_grants_full", 32'(grants), 32'd4);
    chk("t2_stall_full", 32'(o_stall), 32'd1);
    chk("t2_req_full", 32'(o_req), 32'd0);
    i_ready = 1'b1;
    wait_pops("t2_pops", 8, 100);
    chk("t2_resume_gap", 32'(resume - first_pop), 32'd1);

    // 3-cycle memory latency.
    do_reset();
    lat = 3; i_gnt = 1'b1; i_ready = 1'b1; i_pc = 32'h80; left = 10;
    wait_pops("t3_pops", 10, 120);
    chk("t3_max_outstanding", 32'(max_out), 32'd3);

    // Flush with one filled entry and two responses in flight.
    do_reset();
    lat = 1; i_gnt = 1'b1; i_ready = 1'b0; i_pc = 32'h300; left = 1;
    for (int k = 0; k < 20 && first_valid < 0; k++) step();
    chk("t4_first_filled", 32'(first_valid >= 0), 32'd1);
    hold = 1'b1; left = 2;
    repeat (3) step();
    chk("t4_grants", 32'(grants), 32'd3);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("t4_valid_after_flush", 32'(o_valid), 32'd0);
    hold = 1'b0; i_ready = 1'b1; i_pc = 32'h100; left = 1;
    wait_pops("t4_pops", 1, 50);
    repeat (6) step();
    chk("t4_no_stray", 32'(pops), 32'd1);

    // Flush in the same cycle as a response, two outstanding.
    do_reset();
    lat = 1; i_gnt = 1'b1; i_ready = 1'b1; hold = 1'b1; i_pc = 32'h500; left = 2;
    repeat (3) step();
    i_flush = 1'b1; hold = 1'b0;
    step();
    i_flush = 1'b0; i_pc = 32'h200; left = 1;
    wait_pops("t5_pops", 1, 50);
    repeat (6) step();
    chk("t5_no_stray", 32'(pops), 32'd1);
    chk("t5_grants", 32'(grants), 32'd3);

`ifdef IFQ_ALIGN_CHECK_EN
    // Misaligned PC is queued without a memory request.
    do_reset();
    lat = 1; i_gnt = 1'b1; i_ready = 1'b1; i_pc = 32'h6; left = 1;
    i_pc_ce = 1'b1;
    #1;
    chk("t6_mis_req", 32'(o_req), 32'd0);
    chk("t6_mis_stall", 32'(o_stall), 32'd0);
    step();
    i_pc = 32'h8; left = 1;
    wait_pops("t6_pops", 2, 30);
    chk("t6_grants", 32'(grants), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Fetch stage between the program-counter register and the IF/ID decode boundary. Takes the sequential PC stream and issues in-order requests to instruction memory over a req/gnt/rvalid handshake. Pairs each returned word with its PC in a DEPTH-entry queue and presents it to decode with valid/ready. Supports pipeline flush, including discard of responses still in flight.

Parameters:
DEPTH, 4, queue entries and maximum outstanding requests; power of 2, minimum 2
AW, 32, address/PC width
DW, 32, instruction width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
pc_i  input  AW  current PC from PC register
pc_ce_i  input  1  PC valid (chip enable from PC register)
stall_req_o  output  1  asks PC register to hold pc_i this cycle
flush_i  input  1  drop queue contents and in-flight responses
imem_req_o  output  1  fetch request
imem_addr_o  output  AW  fetch address (equals pc_i)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in order, latency ≥1 cycle
imem_rdata_i  input  DW  response data
id_valid_o  output  1  head entry complete
id_pc_o  output  AW  head PC
id_inst_o  output  DW  head instruction
id_ready_i  input  1  decode accepts head

Behaviour:
- Reset: queue count, head/tail pointers, fill bits, outstanding and discard counters all 0. While rst is high, imem_req_o, stall_req_o and id_valid_o are 0. id_pc_o and id_inst_o are 0 after reset until the first entry fills.
- Entry fields: pc, inst, filled bit. Allocation happens at issue; the fill happens at response.
- Credit check: credit = (count < DEPTH). count includes allocated-but-unfilled entries.
- Request logic:
  - imem_req_o = pc_ce_i & credit & !flush_i & !rst.
  - imem_addr_o = pc_i (combinational).
  - Issue occurs when imem_req_o & imem_gnt_i. On issue: allocate tail with pc_i, filled=0, then increment tail.
- Stall: stall_req_o = pc_ce_i & !(imem_req_o & imem_gnt_i). The PC register must hold pc_i while stall_req_o is high.
- Response handling (imem_rvalid_i):
  - If discard_cnt > 0: decrement discard_cnt and drop the data.
  - Otherwise: write inst into the oldest unfilled entry, set filled, advance the fill pointer.
  - A response with no outstanding request is a protocol error; ignore it (assertion in bench).
- Decode output:
  - id_valid_o = count>0 & head.filled & !flush_i.
  - Pop occurs when id_valid_o & id_ready_i, which advances head.
  - Pop, issue and response may all happen in the same cycle; count = count + issue − pop.
- Full/empty and latency:
  - Full (count==DEPTH): no request, stall asserted. A pop in the same cycle does NOT free credit until the next cycle.
  - Empty: id_valid_o=0.
  - Minimum latency is 2 cycles from issue to id_valid_o (1-cycle memory plus registered fill).
- Pointers: log2(DEPTH) bits, wrapping naturally. count is log2(DEPTH)+1 bits.
- Flush (flush_i=1):
  - Next cycle: count, head, tail and fill pointer are 0.
  - discard_cnt is loaded with the number of unfilled entries, minus 1 if a response arrives in the flush cycle (that response is dropped).
  - No issue happens in the flush cycle.
  - Flush has priority over pop, issue and fill.
- Issue while discarding: allowed. New responses are matched only after discard_cnt reaches 0, which the in-order rule guarantees.
- rst mid-operation clears everything, including discard_cnt. The memory side must also be reset.

Optional Feature:
IFQ_ALIGN_CHECK_EN:
- With the macro defined:
  - A pc_i with pc_i[1:0]≠0 is not sent to memory (imem_req_o=0). If credit allows, an entry is allocated with filled=1, inst=0 and a misalign flag, and consumes the PC that cycle (stall_req_o=0).
  - Adds output id_misalign_o (1 bit), which is the head's flag, gated by id_valid_o.
- Without the macro: no check is made, all PCs are issued, and the port is absent.

Test Plan:
1. Reset then ce=1, pc 0x0,0x4,0x8; memory 1-cycle latency, rdata=addr^0xFFFF0000; id_ready=1 → id pairs (0x0,0xFFFF0000),(0x4,0xFFFF0004),(0x8,0xFFFF0008) in order, first id_valid_o 2 cycles after first grant.
2. id_ready=0, gnt=1 continuous → exactly DEPTH=4 grants, then stall_req_o=1 and imem_req_o=0. Raise id_ready → one pop per cycle; issue resumes 1 cycle after first pop.
3. Memory latency 3, gnt=1 → up to 3 outstanding; outputs in order with no gaps once steady; count never exceeds 4.
4. Two requests in flight, queue holds 1 filled entry, assert flush_i → next cycle id_valid_o=0, count=0. Next 2 rvalid dropped; new pc 0x100 fetch returns as the first id output.
5. Flush in the same cycle as rvalid, with 2 outstanding → discard_cnt=1; only 1 later response dropped.
6. (IFQ_ALIGN_CHECK_EN) pc_i=0x6 → no imem_req_o; id output pc 0x6, inst 0, id_misalign_o=1; following pc 0x8 fetched normally.
